// File: rtl/sample_rom_cache_pkg.sv
// Shared widths, state encoding and address helpers for the sample ROM cache.
package sample_rom_cache_pkg;

   localparam int SAMPLE_LINE_W = 64;
   localparam int ADDR_W        = 25;
   localparam int LINE_W        = ADDR_W - 3;

   typedef enum logic [2:0] {
      ST_FLUSH,
      ST_IDLE,
      ST_LOOKUP,
      ST_FILL,
      ST_PREF
   } state_e;

   function automatic logic [ADDR_W-1:0] line_to_addr(input logic [LINE_W-1:0] line);
      return {line, 3'b000};
   endfunction

endpackage

// File: rtl/sample_rom_cache_if.sv
// Toggle-handshake line port: a request is pending while req != ack.
interface sample_rom_cache_if;
   import sample_rom_cache_pkg::*;

   logic [ADDR_W-1:0]        addr;
   logic                     req;
   logic                     ack;
   logic [SAMPLE_LINE_W-1:0] data;

   modport master (output addr, output req, input ack, input data);
   modport slave  (input addr, input req, output ack, output data);

endinterface

// File: rtl/sample_cache_ram.sv
// Single-clock simple dual-port RAM with registered read; a same-address
// read during a write returns the old contents.
module sample_cache_ram #(
   parameter int AW = 6,
   parameter int DW = 80
) (
   input  logic          clk_sys,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_q;

   // NOTE: the array has no reset so it maps onto block RAM; the valid flops gate its contents.
   always_ff @(posedge clk_sys) begin
      if (we) mem[waddr] <= wdata;
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sample_rom_cache.sv
// Direct-mapped 64-bit line cache between the sample ROM toggle port and the
// SDRAM sample port, with optional next-line prefetch after each miss.
module sample_rom_cache
   import sample_rom_cache_pkg::*;
#(
   parameter int IDX_W    = 6,
   parameter int PREFETCH = 1
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               flush,
   sample_rom_cache_if.slave  cpu,
   sample_rom_cache_if.master sdr,
   output logic               busy
);

   localparam int LINES = 2**IDX_W;
   localparam int TAG_W = LINE_W - IDX_W;
   localparam int RAM_W = TAG_W + SAMPLE_LINE_W;

   state_e                   state_q, state_d;
   logic [LINE_W-1:0]        line_q, line_d;
   logic [IDX_W-1:0]         cnt_q, cnt_d;
   logic                     swept_q, swept_d;
   logic                     kill_q, kill_d;
   logic                     lookup_wait_q, lookup_wait_d;
   logic [LINES-1:0]         valid_q, valid_d;
   logic                     cpu_ack_q, cpu_ack_d;
   logic [SAMPLE_LINE_W-1:0] cpu_dout_q, cpu_dout_d;
   logic [ADDR_W-1:0]        sdr_addr_q, sdr_addr_d;
   logic                     sdr_req_q, sdr_req_d;

   logic                     ram_we;
   logic [IDX_W-1:0]         ram_waddr;
   logic [RAM_W-1:0]         ram_wdata;
   logic [RAM_W-1:0]         ram_rdata;
   logic [TAG_W-1:0]         rd_tag;
   logic [SAMPLE_LINE_W-1:0] rd_data;
   logic [LINE_W-1:0]        next_line;
   logic [LINE_W-1:0]        pref_line;
   logic                     sdr_idle;
   logic                     req_pend;
   logic                     hit;
   logic                     addr_lsb_unused;

   sample_cache_ram #(.AW(IDX_W), .DW(RAM_W)) u_ram (
      .clk_sys (clk_sys),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr   (line_q[IDX_W-1:0]),
      .rdata   (ram_rdata)
   );

   assign rd_tag          = ram_rdata[RAM_W-1 -: TAG_W];
   assign rd_data         = ram_rdata[SAMPLE_LINE_W-1:0];
   assign next_line       = line_q + 1'b1;
   assign pref_line       = sdr_addr_q[ADDR_W-1:3];
   assign sdr_idle        = (sdr_req_q == sdr.ack);
   assign req_pend        = (cpu.req != cpu_ack_q);
   assign hit             = valid_q[line_q[IDX_W-1:0]] && (rd_tag == line_q[LINE_W-1:IDX_W]);
   assign addr_lsb_unused = ^cpu.addr[2:0];

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      cnt_d         = cnt_q;
      swept_d       = swept_q;
      kill_d        = kill_q;
      lookup_wait_d = lookup_wait_q;
      valid_d       = valid_q;
      cpu_ack_d     = cpu_ack_q;
      cpu_dout_d    = cpu_dout_q;
      sdr_addr_d    = sdr_addr_q;
      sdr_req_d     = sdr_req_q;
      ram_we        = 1'b0;
      ram_waddr     = line_q[IDX_W-1:0];
      ram_wdata     = {line_q[LINE_W-1:IDX_W], sdr.data};

      case (state_q)
         ST_FLUSH: begin
            kill_d = 1'b0;
            if (!swept_q) begin
               valid_d[cnt_q] = 1'b0;
               cnt_d          = cnt_q + 1'b1;
            end
            // Leave only once the sweep is done and any stray fill has drained.
            if (swept_q || (&cnt_q)) begin
               swept_d = 1'b1;
               if (!flush && sdr_idle) state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (flush) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
               swept_d = 1'b0;
            end else if (req_pend) begin
               line_d        = cpu.addr[ADDR_W-1:3];
               lookup_wait_d = 1'b1;
               state_d       = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (lookup_wait_q) begin
               lookup_wait_d = 1'b0;
            end else if (hit) begin
               cpu_dout_d = rd_data;
               cpu_ack_d  = ~cpu_ack_q;
               state_d    = ST_IDLE;
            end else begin
               sdr_addr_d = line_to_addr(line_q);
               sdr_req_d  = ~sdr_req_q;
               kill_d     = flush;
               state_d    = ST_FILL;
            end
         end
         ST_FILL: begin
            kill_d = kill_q | flush;
            if (sdr_idle) begin
               cpu_dout_d = sdr.data;
               cpu_ack_d  = ~cpu_ack_q;
               if (kill_d) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
                  swept_d = 1'b0;
               end else begin
                  ram_we                       = 1'b1;
                  valid_d[line_q[IDX_W-1:0]]   = 1'b1;
                  if (PREFETCH != 0 && !(&line_q)) begin
                     sdr_addr_d = line_to_addr(next_line);
                     sdr_req_d  = ~sdr_req_q;
                     state_d    = ST_PREF;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_PREF: begin
            kill_d = kill_q | flush;
            if (sdr_idle) begin
               if (kill_d) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
                  swept_d = 1'b0;
               end else begin
                  ram_we                          = 1'b1;
                  ram_waddr                       = pref_line[IDX_W-1:0];
                  ram_wdata                       = {pref_line[LINE_W-1:IDX_W], sdr.data};
                  valid_d[pref_line[IDX_W-1:0]]   = 1'b1;
                  state_d                         = ST_IDLE;
               end
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q       <= ST_FLUSH;
         line_q        <= '0;
         cnt_q         <= '0;
         swept_q       <= 1'b0;
         kill_q        <= 1'b0;
         lookup_wait_q <= 1'b0;
         valid_q       <= '0;
         cpu_ack_q     <= 1'b0;
         cpu_dout_q    <= '0;
         sdr_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         cnt_q         <= cnt_d;
         swept_q       <= swept_d;
         kill_q        <= kill_d;
         lookup_wait_q <= lookup_wait_d;
         valid_q       <= valid_d;
         cpu_ack_q     <= cpu_ack_d;
         cpu_dout_q    <= cpu_dout_d;
         sdr_addr_q    <= sdr_addr_d;
      end
   end

   // Deliberately outside reset: the SDRAM side keeps its toggle phase across a cache reset.
   always_ff @(posedge clk_sys) begin
      sdr_req_q <= sdr_req_d;
   end

   assign cpu.ack  = cpu_ack_q;
   assign cpu.data = cpu_dout_q;
   assign sdr.addr = sdr_addr_q;
   assign sdr.req  = sdr_req_q;
   assign busy     = (state_q != ST_IDLE && state_q != ST_LOOKUP) || !sdr_idle;

endmodule

// File: tb/tb_sample_rom_cache.sv
// Scoreboard bench for sample_rom_cache: a line-level cache model predicts
// returned data, SDRAM fetch addresses and hit latency.
module tb_sample_rom_cache;
   import sample_rom_cache_pkg::*;

   localparam int IDX_W    = 6;
   localparam int LINES    = 2**IDX_W;
   localparam int PREFETCH = 1;

   typedef struct {
      logic [63:0] data;
      int          lat;
      int          t0;
   } exp_t;

   logic clk_sys = 1'b0;
   logic reset;
   logic flush;
   logic busy;
   int   cyc = 0;

   sample_rom_cache_if cpu ();
   sample_rom_cache_if sdr ();

   sample_rom_cache #(.IDX_W(IDX_W), .PREFETCH(PREFETCH)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .flush   (flush),
      .cpu     (cpu),
      .sdr     (sdr),
      .busy    (busy)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        exp_q[$];
   logic [24:0] sdr_exp_q[$];
   bit          m_valid[LINES];
   logic [21:0] m_line[LINES];
   int          m_fetches = 0;
   int          n_fetch = 0;
   int          sdr_lat = 2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sample ROM contents as seen through SDRAM, keyed by line number.
   function automatic logic [63:0] rom_word(input logic [21:0] line);
      if (line == 22'h020008) return 64'h1122334455667788;
      return {10'h2A5, line, 10'h15A, ~line};
   endfunction

   function automatic void m_flush();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
   endfunction

   function automatic void m_fetch(input logic [21:0] line, input bit keep);
      sdr_exp_q.push_back({line, 3'b000});
      m_fetches++;
      if (keep) begin
         m_valid[int'(line) % LINES] = 1'b1;
         m_line[int'(line) % LINES]  = line;
      end
   endfunction

   // Issue one client request; 'killed' means a flush or reset will hit its fill.
   task automatic issue(input logic [24:0] addr, input bit killed, input bit timed);
      int          guard;
      logic [21:0] line;
      bit          hit;
      exp_t        e;
      guard = 0;
      @(posedge clk_sys); #1;
      while (cpu.ack !== cpu.req && guard < 4000) begin
         @(posedge clk_sys); #1;
         guard++;
      end
      check("issue_wait_bound", 64'(guard < 4000), 64'd1);
      line = addr[24:3];
      hit  = m_valid[int'(line) % LINES] && (m_line[int'(line) % LINES] == line);
      if (killed) begin
         m_fetch(line, 1'b0);
         m_flush();
      end else if (!hit) begin
         m_fetch(line, 1'b1);
         if (PREFETCH != 0 && line != 22'h3FFFFF) m_fetch(line + 22'd1, 1'b1);
      end
      e.data = rom_word(line);
      e.lat  = (timed && hit) ? 3 : -1;
      e.t0   = cyc;
      exp_q.push_back(e);
      cpu.addr = addr;
      cpu.req  = ~cpu.req;
   endtask

   task automatic settle();
      int guard;
      guard = 0;
      @(posedge clk_sys); #1;
      while ((exp_q.size() != 0 || busy || sdr_exp_q.size() != 0) && guard < 5000) begin
         @(posedge clk_sys); #1;
         guard++;
      end
      check("settle_bound", 64'(guard < 5000), 64'd1);
      check("fetch_count", 64'(n_fetch), 64'(m_fetches));
   endtask

   task automatic count_busy(output int n);
      n = 0;
      do begin
         @(posedge clk_sys); #1;
         n++;
      end while (busy && n < 400);
   endtask

   // Monitor: every cpu_ack toggle outside reset pops one expected response.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            prev = cpu.ack;
         end else if (cpu.ack !== prev) begin
            prev = cpu.ack;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_ack: cpu_ack toggled to %b with nothing outstanding", cpu.ack);
            end else begin
               e = exp_q.pop_front();
               if (cpu.data !== e.data) begin
                  n_bad++;
                  $display("FAIL cpu_dout: got %h, expected %h", cpu.data, e.data);
               end
               if (e.lat >= 0) check("hit_latency", 64'(cyc - e.t0), 64'(e.lat));
            end
         end
      end
   end

   // SDRAM responder: answers each sdr_req toggle after sdr_lat cycles.
   initial begin
      logic [24:0] a;
      sdr.ack  = 1'b0;
      sdr.data = '0;
      forever begin
         @(posedge clk_sys); #1;
         if (sdr.req !== sdr.ack) begin
            a = sdr.addr;
            n_fetch++;
            n_cmp++;
            if (sdr_exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_fetch: sdr_addr %h requested", a);
            end else if (a !== sdr_exp_q[0]) begin
               n_bad++;
               $display("FAIL sdr_addr: got %h, expected %h", a, sdr_exp_q[0]);
               void'(sdr_exp_q.pop_front());
            end else begin
               void'(sdr_exp_q.pop_front());
            end
            repeat (sdr_lat) @(posedge clk_sys);
            #1;
            sdr.data = rom_word(a[24:3]);
            sdr.ack  = ~sdr.ack;
         end
      end
   end

   initial begin
      int n;
      logic [24:0] ra;
      reset    = 1'b1;
      flush    = 1'b0;
      cpu.req  = 1'b0;
      cpu.addr = '0;
      m_flush();
      repeat (3) @(posedge clk_sys);
      #1;
      check("reset_cpu_ack", 64'(cpu.ack), 64'd0);
      check("reset_cpu_dout", cpu.data, 64'd0);
      check("reset_sdr_addr", 64'(sdr.addr), 64'd0);
      check("reset_busy", 64'(busy), 64'd1);

      // Power-up sweep, then first miss with its automatic prefetch.
      reset = 1'b0;
      count_busy(n);
      check("flush_sweep_cycles", 64'(n), 64'd64);
      issue(25'h0100040, 1'b0, 1'b1);
      settle();

      // Prefetched line hits with no SDRAM traffic.
      issue(25'h0100048, 1'b0, 1'b1);
      settle();

      // Same index, different tag: mutual eviction.
      issue(25'h0100240, 1'b0, 1'b1);
      settle();
      issue(25'h0100040, 1'b0, 1'b1);
      settle();
      issue(25'h0100040, 1'b0, 1'b1);
      settle();

      // Top line: no prefetch past the end of the ROM.
      issue(25'h1FFFFF8, 1'b0, 1'b1);
      settle();

      // Flush pulse during a fill: data still returned, nothing retained.
      sdr_lat = 12;
      issue(25'h0123450, 1'b1, 1'b0);
      repeat (4) @(posedge clk_sys);
      #1 flush = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1 flush = 1'b0;
      settle();
      sdr_lat = 2;
      issue(25'h0123450, 1'b0, 1'b1);
      settle();
      issue(25'h0100048, 1'b0, 1'b1);
      settle();

      // Reset mid-fill with a response that outlasts the sweep.
      sdr_lat = 90;
      issue(25'h0155558, 1'b1, 1'b0);
      repeat (6) @(posedge clk_sys);
      #1;
      reset   = 1'b1;
      cpu.req = 1'b0;
      exp_q.delete();
      m_flush();
      repeat (2) @(posedge clk_sys);
      #1;
      check("reset_mid_fill_ack", 64'(cpu.ack), 64'd0);
      reset = 1'b0;
      count_busy(n);
      check("drain_outlasts_sweep", 64'(n >= 65), 64'd1);
      check("req_ack_in_sync", 64'(sdr.req), 64'(sdr.ack));
      sdr_lat = 2;
      issue(25'h0155558, 1'b0, 1'b1);
      settle();

      // Randomised back-to-back traffic over a small working set.
      for (int i = 0; i < 60; i++) begin
         sdr_lat = $urandom_range(1, 6);
         if ($urandom_range(0, 7) == 0) ra = 25'($urandom);
         else ra = 25'h0100000 + 25'($urandom_range(0, 95) * 8) + 25'($urandom_range(0, 7));
         issue(ra, 1'b0, 1'b0);
      end
      settle();
      check("final_unacked", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
